// File: rtl/vga_pkg.sv
// Shared VGA constants and the timing bundle carried through every draw stage.
// Missile geometry lives here so the missile controller and this overlay agree on it.
package vga_pkg;
   localparam int H_ACTIVE = 1024;
   localparam int V_ACTIVE = 768;
   localparam int CNT_W    = 11;
   localparam int RGB_W    = 12;

   localparam int M_WIDTH  = 4;
   localparam int M_HEIGHT = 16;
   localparam int X_OFFSET = 22;
   localparam int TIP_ROWS = 4;

   typedef struct packed {
      logic [CNT_W-1:0] hcount;
      logic [CNT_W-1:0] vcount;
      logic             hsync;
      logic             vsync;
      logic             hblnk;
      logic             vblnk;
      logic [RGB_W-1:0] rgb;
   } vga_bus_t;
endpackage

// File: rtl/vga_delay.sv
// N-stage register for the VGA timing bundle, synchronously cleared to zero.
module vga_delay
   import vga_pkg::*;
#(
   parameter int N = 1
) (
   input  logic             pclk,
   input  logic             rst,
   input  logic [CNT_W-1:0] hcount_in,
   input  logic [CNT_W-1:0] vcount_in,
   input  logic             hsync_in,
   input  logic             vsync_in,
   input  logic             hblnk_in,
   input  logic             vblnk_in,
   input  logic [RGB_W-1:0] rgb_in,
   output logic [CNT_W-1:0] hcount_out,
   output logic [CNT_W-1:0] vcount_out,
   output logic             hsync_out,
   output logic             vsync_out,
   output logic             hblnk_out,
   output logic             vblnk_out,
   output logic [RGB_W-1:0] rgb_out
);
   vga_bus_t r_pipe [N];
   vga_bus_t w_in;

   assign w_in = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                   vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in, rgb: rgb_in};

   always_ff @(posedge pclk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) r_pipe[i] <= '0;
      end else begin
         r_pipe[0] <= w_in;
         for (int i = 1; i < N; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign hcount_out = r_pipe[N-1].hcount;
   assign vcount_out = r_pipe[N-1].vcount;
   assign hsync_out  = r_pipe[N-1].hsync;
   assign vsync_out  = r_pipe[N-1].vsync;
   assign hblnk_out  = r_pipe[N-1].hblnk;
   assign vblnk_out  = r_pipe[N-1].vblnk;
   assign rgb_out    = r_pipe[N-1].rgb;
endmodule

// File: rtl/draw_missile.sv
// Overlays the player's missile on the pixel stream with a fixed 2-cycle latency.
// Missile position is latched once per frame at the rising edge of vblank to avoid tearing.
module draw_missile
   import vga_pkg::*;
#(
   parameter int          M_WIDTH    = vga_pkg::M_WIDTH,
   parameter int          M_HEIGHT   = vga_pkg::M_HEIGHT,
   parameter int          X_OFFSET   = vga_pkg::X_OFFSET,
   parameter int          TIP_ROWS   = vga_pkg::TIP_ROWS,
   parameter logic [11:0] BODY_COLOR = 12'hF80,
   parameter logic [11:0] TIP_COLOR  = 12'hFFF
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic [10:0] hcount_in,
   input  logic [10:0] vcount_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        hblnk_in,
   input  logic        vblnk_in,
   input  logic [11:0] rgb_in,
   input  logic [11:0] xpos_in,
   input  logic [11:0] ypos_in,
   input  logic        on_in,
   output logic [10:0] hcount_out,
   output logic [10:0] vcount_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        hblnk_out,
   output logic        vblnk_out,
   output logic [11:0] rgb_out
);
   logic [11:0] r_x_l;
   logic [11:0] r_y_l;
   logic        r_on_l;
   logic        r_vblnk_d;
   logic        r_hit_s1;
   logic        r_tip_s1;

   logic [10:0] w_hcount_s1;
   logic [10:0] w_vcount_s1;
   logic        w_hsync_s1;
   logic        w_vsync_s1;
   logic        w_hblnk_s1;
   logic        w_vblnk_s1;
   logic [11:0] w_rgb_s1;
   logic [11:0] w_rgb_mux;

   logic [12:0] w_h;
   logic [12:0] w_v;
   logic [12:0] w_x_lo;
   logic [12:0] w_x_hi;
   logic [12:0] w_y_lo;
   logic [12:0] w_y_hi;
   logic [12:0] w_dy;
   logic        w_in_x;
   logic        w_in_y;
   logic        w_tip;

   always_ff @(posedge pclk) begin
      if (rst) begin
         r_x_l     <= '0;
         r_y_l     <= '0;
         r_on_l    <= 1'b0;
         r_vblnk_d <= 1'b0;
      end else begin
         r_vblnk_d <= vblnk_in;
         if (vblnk_in && !r_vblnk_d) begin
            r_x_l  <= xpos_in;
            r_y_l  <= ypos_in;
            r_on_l <= on_in;
         end
      end
   end

   // 13-bit arithmetic: a rectangle past the right/bottom edge is clipped, never wrapped.
   assign w_h    = {2'b00, hcount_in};
   assign w_v    = {2'b00, vcount_in};
   assign w_x_lo = {1'b0, r_x_l} + 13'(X_OFFSET);
   assign w_x_hi = w_x_lo + 13'(M_WIDTH);
   assign w_y_lo = {1'b0, r_y_l};
   assign w_y_hi = w_y_lo + 13'(M_HEIGHT);
   assign w_dy   = w_v - w_y_lo;
   assign w_in_x = (w_h >= w_x_lo) && (w_h < w_x_hi);
   assign w_in_y = (w_v >= w_y_lo) && (w_v < w_y_hi);
   assign w_tip  = w_in_y && (w_dy < 13'(TIP_ROWS));

   always_ff @(posedge pclk) begin
      if (rst) begin
         r_hit_s1 <= 1'b0;
         r_tip_s1 <= 1'b0;
      end else begin
         r_hit_s1 <= r_on_l && w_in_x && w_in_y && !hblnk_in && !vblnk_in;
         r_tip_s1 <= w_tip;
      end
   end

   vga_delay #(.N(1)) u_stage1 (
      .pclk(pclk), .rst(rst),
      .hcount_in(hcount_in), .vcount_in(vcount_in),
      .hsync_in(hsync_in), .vsync_in(vsync_in),
      .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
      .hcount_out(w_hcount_s1), .vcount_out(w_vcount_s1),
      .hsync_out(w_hsync_s1), .vsync_out(w_vsync_s1),
      .hblnk_out(w_hblnk_s1), .vblnk_out(w_vblnk_s1), .rgb_out(w_rgb_s1)
   );

   assign w_rgb_mux = r_hit_s1 ? (r_tip_s1 ? TIP_COLOR : BODY_COLOR) : w_rgb_s1;

   vga_delay #(.N(1)) u_stage2 (
      .pclk(pclk), .rst(rst),
      .hcount_in(w_hcount_s1), .vcount_in(w_vcount_s1),
      .hsync_in(w_hsync_s1), .vsync_in(w_vsync_s1),
      .hblnk_in(w_hblnk_s1), .vblnk_in(w_vblnk_s1), .rgb_in(w_rgb_mux),
      .hcount_out(hcount_out), .vcount_out(vcount_out),
      .hsync_out(hsync_out), .vsync_out(vsync_out),
      .hblnk_out(hblnk_out), .vblnk_out(vblnk_out), .rgb_out(rgb_out)
   );
endmodule

// File: tb/tb_draw_missile.sv
// Directed bench for draw_missile: each step drives one pixel and queues the
// expected output bundle, which is checked two cycles later.
module tb_draw_missile;
   logic        pclk = 1'b0;
   logic        rst;
   logic [10:0] hcount_in, vcount_in;
   logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
   logic [11:0] rgb_in, xpos_in, ypos_in;
   logic        on_in;
   logic [10:0] hcount_out, vcount_out;
   logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
   logic [11:0] rgb_out;

   always #5 pclk = ~pclk;

   draw_missile dut (
      .pclk(pclk), .rst(rst),
      .hcount_in(hcount_in), .vcount_in(vcount_in),
      .hsync_in(hsync_in), .vsync_in(vsync_in),
      .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
      .xpos_in(xpos_in), .ypos_in(ypos_in), .on_in(on_in),
      .hcount_out(hcount_out), .vcount_out(vcount_out),
      .hsync_out(hsync_out), .vsync_out(vsync_out),
      .hblnk_out(hblnk_out), .vblnk_out(vblnk_out), .rgb_out(rgb_out)
   );

   logic [37:0] exp_q[$];
   string       tag_q[$];
   int          n_eval = 0;
   int          n_fail = 0;

   // reference latch state and the controller values to present at the next step
   int          m_x = 0, m_y = 0;
   bit          m_on = 0, m_vd = 0;
   int          nx_x = 0, nx_y = 0;
   bit          nx_on = 0;
   bit          fix_en = 0;
   logic [11:0] fix_rgb = '0;
   string       cur_tag = "init";

   task automatic step(input bit r, input int h, input int v, input bit hb, input bit vb);
      logic [37:0] got, expv;
      logic [11:0] rgb, orgb;
      bit          hs, vs, hit, tip;
      int          xl;
      string       tg;
      @(negedge pclk);
      if (exp_q.size() == 2) begin
         expv = exp_q.pop_front();
         tg   = tag_q.pop_front();
         got  = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};
         n_eval++;
         assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tg, got, expv);
         end
      end
      rgb = fix_en ? fix_rgb : 12'($urandom_range(0, 4095));
      hs  = 1'($urandom_range(0, 1));
      vs  = 1'($urandom_range(0, 1));
      rst = r; hcount_in = 11'(h); vcount_in = 11'(v);
      hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb; rgb_in = rgb;
      xpos_in = 12'(nx_x); ypos_in = 12'(nx_y); on_in = nx_on;
      tag_q.push_back($sformatf("%s(%0d,%0d)", cur_tag, h, v));
      if (r) begin
         if (exp_q.size() > 0) exp_q[exp_q.size()-1] = '0;
         exp_q.push_back('0);
         m_x = 0; m_y = 0; m_on = 0; m_vd = 0;
      end else begin
         xl   = m_x + 22;
         hit  = m_on && h >= xl && h < xl + 4 && v >= m_y && v < m_y + 16 && !hb && !vb;
         tip  = (v - m_y) < 4;
         orgb = hit ? (tip ? 12'hFFF : 12'hF80) : rgb;
         exp_q.push_back({11'(h), 11'(v), hs, vs, hb, vb, orgb});
         if (vb && !m_vd) begin
            m_x = nx_x; m_y = nx_y; m_on = nx_on;
         end
         m_vd = vb;
      end
   endtask

   task automatic vblank_burst();
      for (int i = 0; i < 4; i++) step(0, i, 768 + i, 1, 1);
   endtask

   task automatic row(input int v, input int h0, input int h1);
      for (int h = h0; h <= h1; h++) step(0, h, v, 0, 0);
   endtask

   initial begin
      rst = 1'b1; hcount_in = '0; vcount_in = '0; hsync_in = 0; vsync_in = 0;
      hblnk_in = 0; vblnk_in = 0; rgb_in = '0; xpos_in = '0; ypos_in = '0; on_in = 0;

      cur_tag = "reset";
      for (int i = 0; i < 3; i++) step(1, 10 + i, 20, 0, 0);
      cur_tag = "pass"; fix_en = 1; fix_rgb = 12'h123;
      for (int i = 0; i < 4; i++) step(0, 200 + i, 300, 0, 0);
      fix_en = 0;
      row(301, 0, 7);

      cur_tag = "draw"; nx_on = 1; nx_x = 100; nx_y = 500;
      vblank_burst();
      step(0, 122, 500, 0, 0); step(0, 125, 504, 0, 0); step(0, 125, 515, 0, 0);
      step(0, 121, 510, 0, 0); step(0, 126, 510, 0, 0); step(0, 125, 516, 0, 0);
      step(0, 123, 503, 0, 0); step(0, 124, 499, 0, 0);
      step(0, 123, 505, 1, 0);
      row(508, 118, 129);

      cur_tag = "tear"; nx_x = 300;
      step(0, 10, 400, 0, 0);
      row(502, 120, 127); row(502, 320, 327);
      vblank_burst();
      cur_tag = "tear_next";
      row(502, 120, 127); row(502, 320, 327);

      cur_tag = "off"; nx_on = 0;
      vblank_burst();
      row(505, 318, 329); row(505, 120, 127);

      cur_tag = "clip_x"; nx_on = 1; nx_x = 1020; nx_y = 500;
      vblank_burst();
      row(505, 0, 1023);

      cur_tag = "clip_y"; nx_x = 100; nx_y = 760;
      vblank_burst();
      for (int v = 758; v <= 767; v++) row(v, 121, 126);
      for (int v = 0; v <= 7; v++) row(v, 121, 126);

      cur_tag = "midrst"; nx_x = 100; nx_y = 500;
      vblank_burst();
      row(505, 121, 123);
      step(1, 122, 505, 0, 0);
      cur_tag = "after_rst";
      row(506, 120, 127); row(512, 120, 127);
      vblank_burst();
      cur_tag = "rearm";
      row(505, 120, 127);

      cur_tag = "flush";
      step(0, 0, 0, 1, 1); step(0, 0, 0, 1, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
      $finish;
   end
endmodule

// File: doc/draw_missile.md
# draw_missile

Pixel-pipeline stage that overlays the player's missile onto the VGA stream. It sits directly downstream of the missile controller, consuming its `xpos`/`ypos`/`on` outputs, and sits between the background/ship drawing stages and the VGA output register. Missile coordinates are sampled once per frame, at the start of vertical blanking, so the sprite never tears. All timing signals are re-emitted with the same fixed latency as the colour.

## Interface

Parameters:
- `M_WIDTH`, default 4: missile width in pixels.
- `M_HEIGHT`, default 16: missile height in pixels.
- `X_OFFSET`, default 22: horizontal offset added to `xpos_in`. This centres the missile on the 48-px ship: (48-4)/2.
- `TIP_ROWS`, default 4: number of top rows drawn in the tip colour.
- `BODY_COLOR`, default 12'hF80: colour of the missile body.
- `TIP_COLOR`, default 12'hFFF: colour of the tip rows.

Ports:
- `pclk` in, 1: pixel clock; all logic on the rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `hcount_in`, `vcount_in` in, 11 each: pixel coordinates, 1024x768 visible area.
- `hsync_in`, `vsync_in`, `hblnk_in`, `vblnk_in` in, 1 each: timing signals.
- `rgb_in` in, 12: upstream colour, 4:4:4.
- `xpos_in`, `ypos_in` in, 12 each: missile top-left coordinate from the missile controller.
- `on_in` in, 1: missile active.
- `hcount_out`, `vcount_out` out, 11 each: delayed pixel coordinates.
- `hsync_out`, `vsync_out`, `hblnk_out`, `vblnk_out` out, 1 each: delayed timing signals.
- `rgb_out` out, 12: colour with the missile overlaid.

## Operation

Frame latch:
- Registers `x_l`, `y_l`, `on_l` and the edge detector `vblnk_d`.
- On the cycle where `vblnk_in`=1 and `vblnk_d`=0, capture `xpos_in`, `ypos_in`, `on_in`. In every other cycle, hold.
- The latched values are used for the whole following frame. Mid-frame changes on the inputs are ignored.

Stage 1 (hit test):
- `in_x` = `hcount_in` >= `x_l`+`X_OFFSET` AND `hcount_in` < `x_l`+`X_OFFSET`+`M_WIDTH`.
- `in_y` = `vcount_in` >= `y_l` AND `vcount_in` < `y_l`+`M_HEIGHT`.
- `tip` = (`vcount_in` - `y_l`) < `TIP_ROWS`, evaluated only when `in_y` is true.
- All sums and compares are 13-bit zero-extended, so there is no wrap-around. A rectangle extending past 1023 or 767 is clipped, and it never reappears at the left or top edge.
- Register `hit` = `on_l` & `in_x` & `in_y` & !`hblnk_in` & !`vblnk_in`. Register `tip`, `rgb_in` and all timing and coordinate inputs alongside it.

Stage 2 (colour mux):
- `rgb_out` = `hit_s1` ? (`tip_s1` ? `TIP_COLOR` : `BODY_COLOR`) : `rgb_s1`.
- All other outputs copy the stage-1 registers.

## Timing

Latency:
- Exactly 2 `pclk` cycles from any input to the corresponding output.
- The same latency applies to every output, so colour and timing signals stay aligned.

Reset:
- Clears all pipeline registers, so every output is 0 at the next edge.
- Clears `x_l`, `y_l`, `on_l`, `vblnk_d` to 0.

Reset mid-frame:
- The pipeline is flushed and the latch is cleared.
- No missile is drawn until a vblank edge captures `on_in`=1.
- The first valid pass-through colour appears 2 cycles after `rst` falls.

Latch update:
- The latch update is visible to stage 1 one cycle after the vblank edge.
- This falls inside blanking, so no visible pixel ever uses mixed old/new coordinates.

Throughput: one pixel per cycle, with no stalls.

## Structure

Shared package `vga_pkg` holds:
- Resolution constants H_ACTIVE=1024, V_ACTIVE=768.
- Counter width 11 and RGB width 12.
- Missile geometry constants M_WIDTH, M_HEIGHT, X_OFFSET, which the missile controller also uses for its travel limits.

One sub-module, `vga_delay`:
- Parameterised N-stage register for the timing bundle (hcount, vcount, 4 sync/blank bits, rgb).
- Synchronous reset to 0.
- Instantiated with N=1 for stage 1.
- Also reusable by the other draw stages.

## Test plan

- **Reset and pass-through.** Hold `rst` high for 3 cycles: all outputs are 0. Release with `rgb_in`=12'h123 and `on_in`=0: `rgb_out`=12'h123 exactly 2 cycles later, and `hsync_out` equals `hsync_in` delayed by 2.
- **Drawing.** Set `on_in`=1, `xpos_in`=100, `ypos_in`=500, then run a vblank edge. In the next frame:
  - (122,500) → 12'hFFF (tip).
  - (125,504) → 12'hF80 (body).
  - (125,515) → 12'hF80 (body).
  - (121,510), (126,510), (125,516) → `rgb_in` unchanged.
- **No tearing.** Change `xpos_in` to 300 at `vcount`=400 in the same frame: that frame is still drawn at x=122..125. The next frame is drawn at x=322..325.
- **Missile off.** Set `on_in`=0 at a vblank edge: the whole next frame equals `rgb_in` delayed by 2, with no overlay.
- **Edge clipping.** With `xpos_in`=1020: nothing is painted at `hcount` 0..1023, and in particular not at 18..21. With `ypos_in`=760: rows 760..767 are painted and nothing appears at rows 0..7.
- **Reset mid-frame.** Pulse `rst` at (122,505) while the missile is drawn: outputs are 0 on the next edge. After release there is no overlay until a vblank edge occurs with `on_in`=1.
